// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for an accumulator ALU: commands are buffered in a FIFO and
// stepped through issue/wait/hold, with each result held until downstream takes it.
//
// state | meaning
// IDLE  | accumulator persisting; pops the next command when the FIFO is non-empty
// ISSUE | operands and selectors of the popped command presented to the ALU
// WAIT  | ALU output settling; result captured here unless the command was LOAD
// HOLD  | result held on res_* until res_ready
module alu_cmd_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic [2:0] alu_in_selector,
  output logic [7:0] alu_num1,
  output logic [7:0] alu_num2,
  output logic [6:0] alu_out_selector,
  input  logic [7:0] alu_result,
  input  logic       alu_overflow,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic [2:0] res_op,
  output logic       res_overflow,
  output logic       busy,
  output logic [7:0] ovf_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [2:0] OP_LOAD = 3'd7;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} stateT;

  stateT         state, nextState;
  logic [2:0]    opMem [DEPTH];
  logic [7:0]    dataMem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0]   count;
  logic          full, empty, push, pop;
  logic [2:0]    headOp, curOp;
  logic [7:0]    headData;
  logic          inReset, clrPending;

  function automatic logic [6:0] opOneHot(input logic [2:0] op);
    return 7'b1000000 >> op;
  endfunction

  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  assign cmd_ready = !inReset && !full;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && !empty;
  assign headOp    = opMem[rdPtr];
  assign headData  = dataMem[rdPtr];
  assign busy      = (state != IDLE) || !empty;

  // clrPending outlives inReset by one edge so the accumulator clear covers
  // the first cycle after release as well as the reset itself.
  always_ff @(posedge clk) begin
    if (!rst) begin
      inReset    <= 1'b1;
      clrPending <= 1'b1;
    end else begin
      inReset    <= 1'b0;
      clrPending <= inReset;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        opMem[wrPtr]   <= cmd_op;
        dataMem[wrPtr] <= cmd_data;
        wrPtr          <= wrPtr + AW'(1);
      end
      if (pop) rdPtr <= rdPtr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (!empty) nextState = ISSUE;
      ISSUE:   nextState = WAIT;
      WAIT:    nextState = (curOp == OP_LOAD) ? IDLE : HOLD;
      HOLD:    if (res_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    alu_in_selector = 3'b100;
    if (!rst || clrPending)
      alu_in_selector = 3'b001;
    else if (state == ISSUE && curOp == OP_LOAD)
      alu_in_selector = 3'b010;
  end

  // Operand and selector registers load on the pop edge so they are valid for
  // the whole ISSUE cycle and stay put through WAIT.
  always_ff @(posedge clk) begin
    if (!rst) begin
      curOp            <= 3'd0;
      alu_num1         <= 8'h00;
      alu_num2         <= 8'h00;
      alu_out_selector <= 7'b1000000;
      res_valid        <= 1'b0;
      res_data         <= 8'h00;
      res_op           <= 3'd0;
      res_overflow     <= 1'b0;
      ovf_count        <= 8'h00;
    end else begin
      if (pop) begin
        curOp    <= headOp;
        alu_num2 <= headData;
        if (headOp == OP_LOAD) alu_num1 <= headData;
        else                   alu_out_selector <= opOneHot(headOp);
      end
      if (state == WAIT && curOp != OP_LOAD) begin
        res_valid    <= 1'b1;
        res_data     <= alu_result;
        res_op       <= curOp;
        res_overflow <= alu_overflow;
      end
      if (state == HOLD && res_ready) begin
        res_valid <= 1'b0;
        if (res_overflow && ovf_count != 8'hFF) ovf_count <= ovf_count + 8'd1;
      end
    end
  end

endmodule
